// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM states, frame timing, one-hot decode.
package uart_tx_arbiter_pkg;

  // 8N1 frame: start bit, 8 data bits, stop bit
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_BUSY   = 2'd2
  } arb_state_e;

  function automatic int unsigned frame_clks(input int unsigned clks_per_bit);
    return UART_FRAME_BITS * (clks_per_bit + 1);
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake plus transmitter drive and status, shared by arbiter and its users.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Locked;
  logic                 o_Busy;
  logic                 o_Lock_Timeout;

  modport master (
    output i_Req_Valid, i_Req_Byte, i_Req_Last,
    input  o_Req_Ready, o_TX_DV, o_TX_Byte, o_Grant, o_Locked, o_Busy, o_Lock_Timeout
  );

  modport slave (
    input  i_Req_Valid, i_Req_Byte, i_Req_Last,
    output o_Req_Ready, o_TX_DV, o_TX_Byte, o_Grant, o_Locked, o_Busy, o_Lock_Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_core.sv
// Combinational round-robin pick: first eligible request at or above the pointer, wrapping.
module uart_tx_arbiter_rr_core #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic               gnt_valid_c
);

  logic [NUM_REQ-1:0] elig;
  logic [PTR_W-1:0]   idx;

  always_comb begin
    elig        = req_i & mask_i;
    gnt_c       = '0;
    gnt_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!gnt_valid_c && elig[idx]) begin
        gnt_c[idx]  = 1'b1;
        gnt_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmitter among NUM_REQ byte sources with round-robin
// arbitration, per-message locking, lock timeout and an internal frame timer.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned GAP_CLKS     = 0,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input logic              i_Clock,
  input logic              i_Reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned FRAME_CLKS = frame_clks(CLKS_PER_BIT);
  localparam int unsigned BUSY_CLKS  = FRAME_CLKS + GAP_CLKS;
  localparam int unsigned TMR_W      = $clog2(BUSY_CLKS + 1);
  localparam int unsigned PTR_W      = $clog2(NUM_REQ);
  localparam int unsigned CNT_W      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] mask_c, pick_c;
  logic               pick_vld_c;
  logic [PTR_W-1:0]   owner_idx_c;
  logic               owner_vld_c, owner_last_c, tmo_hit_c;
  logic [7:0]         owner_byte_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // A held lock restricts eligibility to the current owner
  assign mask_c       = lock_q ? grant_q : {NUM_REQ{1'b1}};
  assign owner_idx_c  = PTR_W'(onehot_to_idx(8'(grant_q)));
  assign owner_vld_c  = |(bus.i_Req_Valid & grant_q);
  assign owner_last_c = bus.i_Req_Last[owner_idx_c];
  assign owner_byte_c = bus.i_Req_Byte[{owner_idx_c, 3'b000} +: 8];
  assign tmo_hit_c    = (LOCK_TIMEOUT != 0) && lock_q && !owner_vld_c &&
                        ((32'(cnt_q) + 32'd1) == LOCK_TIMEOUT);

  uart_tx_arbiter_rr_core #(.NUM_REQ(NUM_REQ)) u_rr_core (
    .req_i       (bus.i_Req_Valid),
    .ptr_i       (ptr_q),
    .mask_i      (mask_c),
    .gnt_c       (pick_c),
    .gnt_valid_c (pick_vld_c)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    tmo_d   = 1'b0;

    // Stall counter only advances in IDLE while a lock waits on a silent owner
    if (!lock_q || owner_vld_c) begin
      cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (state_q == ST_IDLE && tmo_hit_c) begin
          lock_d = 1'b0;
          tmo_d  = 1'b1;
          ptr_d  = ptr_inc(owner_idx_c);
          cnt_d  = '0;
        end else if (pick_vld_c) begin
          grant_d = pick_c;
          ready_d = pick_c;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (owner_vld_c) begin
          byte_d  = owner_byte_c;
          dv_d    = 1'b1;
          tmr_d   = TMR_W'(BUSY_CLKS);
          state_d = ST_BUSY;
          if (owner_last_c) begin
            lock_d = 1'b0;
            ptr_d  = ptr_inc(owner_idx_c);
          end else begin
            lock_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
        if (tmr_q <= TMR_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_BUSY);
  end

  // Reset parks in BUSY with a full reload so a frame already on the wire drains
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_BUSY;
      tmr_q   <= TMR_W'(BUSY_CLKS);
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      grant_q <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_Req_Ready    = ready_q;
  assign bus.o_TX_DV        = dv_q;
  assign bus.o_TX_Byte      = byte_q;
  assign bus.o_Grant        = grant_q;
  assign bus.o_Locked       = lock_q;
  assign bus.o_Busy         = busy_q;
  assign bus.o_Lock_Timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: CLKS_PER_BIT=4, GAP_CLKS=2 (52-cycle busy window), 4 requesters, timeout 20.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CPB  = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned LTO  = 20;
  // Edges from a DV pulse (or reset release) to the next Ready: 52 busy + 1 idle
  localparam int LAT = 53;

  logic  clk = 1'b0;
  logic  rst;
  logic  prev_busy;
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus();

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .CLKS_PER_BIT (CPB),
    .GAP_CLKS     (GAP),
    .LOCK_TIMEOUT (LTO)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h, expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock; every cycle checks Ready one-hot and that DV only starts a new busy window
  task automatic step();
    @(posedge clk);
    #1;
    chk("ready_onehot0", 32'($onehot0(bus.o_Req_Ready)), 32'd1);
    if (bus.o_TX_DV) begin
      chk("dv_while_busy", 32'(prev_busy), 32'd0);
      chk("dv_sets_busy", 32'(bus.o_Busy), 32'd1);
    end
    prev_busy = bus.o_Busy;
  endtask

  task automatic set_req(input logic [1:0] r, input logic v, input logic [7:0] b, input logic l);
    bus.i_Req_Valid[r]               = v;
    bus.i_Req_Byte[{r, 3'b000} +: 8] = b;
    bus.i_Req_Last[r]                = l;
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.o_Req_Ready == '0 && n < max);
  endtask

  task automatic chk_reset();
    chk("rst_ready", 32'(bus.o_Req_Ready), 32'd0);
    chk("rst_dv", 32'(bus.o_TX_DV), 32'd0);
    chk("rst_byte", 32'(bus.o_TX_Byte), 32'd0);
    chk("rst_grant", 32'(bus.o_Grant), 32'd0);
    chk("rst_locked", 32'(bus.o_Locked), 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd1);
    chk("rst_tmo", 32'(bus.o_Lock_Timeout), 32'd0);
  endtask

  // Expect Ready for idx after exp_n edges, then DV with byte b on the following edge
  task automatic xfer(input logic [1:0] idx, input logic [7:0] b, input int exp_n, input logic exp_lock);
    int n;
    wait_ready(100, n);
    chk("ready_latency", 32'(n), 32'(exp_n));
    chk("ready_vec", 32'(bus.o_Req_Ready), 32'd1 << idx);
    step();
    chk("tx_dv", 32'(bus.o_TX_DV), 32'd1);
    chk("tx_byte", 32'(bus.o_TX_Byte), 32'(b));
    chk("grant", 32'(bus.o_Grant), 32'd1 << idx);
    chk("locked", 32'(bus.o_Locked), 32'(exp_lock));
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    prev_busy       = 1'b1;
    bus.i_Req_Valid = '0;
    bus.i_Req_Byte  = '0;
    bus.i_Req_Last  = '0;

    phase = "reset";
    step();
    step();
    chk_reset();

    // 1: request pending across reset release waits for the full drain
    phase = "t1_drain";
    set_req(2'd0, 1'b1, 8'hA5, 1'b1);
    rst = 1'b0;
    xfer(2'd0, 8'hA5, LAT, 1'b0);
    set_req(2'd0, 1'b0, 8'h00, 1'b0);

    // 2: all four contend; rotation 0,1,2,3,0 with 54-cycle DV spacing
    phase = "t2_rotate";
    for (int r = 0; r < 4; r++) set_req(2'(r), 1'b1, 8'(8'h10 + r), 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    xfer(2'd0, 8'h10, LAT, 1'b0);
    set_req(2'd0, 1'b1, 8'h20, 1'b1);
    xfer(2'd1, 8'h11, LAT, 1'b0);
    set_req(2'd1, 1'b0, 8'h00, 1'b0);
    xfer(2'd2, 8'h12, LAT, 1'b0);
    set_req(2'd2, 1'b0, 8'h00, 1'b0);
    xfer(2'd3, 8'h13, LAT, 1'b0);
    set_req(2'd3, 1'b0, 8'h00, 1'b0);
    xfer(2'd0, 8'h20, LAT, 1'b0);
    set_req(2'd0, 1'b0, 8'h00, 1'b0);

    // 3: three-byte message from req1 holds the line against req2
    phase = "t3_lock";
    set_req(2'd1, 1'b1, 8'h31, 1'b0);
    set_req(2'd2, 1'b1, 8'h42, 1'b1);
    xfer(2'd1, 8'h31, LAT, 1'b1);
    set_req(2'd1, 1'b1, 8'h32, 1'b0);
    xfer(2'd1, 8'h32, LAT, 1'b1);
    set_req(2'd1, 1'b1, 8'h33, 1'b1);
    xfer(2'd1, 8'h33, LAT, 1'b0);
    set_req(2'd1, 1'b0, 8'h00, 1'b0);
    xfer(2'd2, 8'h42, LAT, 1'b0);
    set_req(2'd2, 1'b0, 8'h00, 1'b0);

    // 4: locked owner goes silent for 20 idle cycles -> revoke, req2 takes over
    phase = "t4_timeout";
    set_req(2'd1, 1'b1, 8'h51, 1'b0);
    set_req(2'd2, 1'b1, 8'h62, 1'b1);
    xfer(2'd1, 8'h51, LAT, 1'b1);
    set_req(2'd1, 1'b0, 8'h00, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.o_Lock_Timeout && n < 120);
    chk("tmo_latency", 32'(n), 32'd72);
    chk("tmo_pulse", 32'(bus.o_Lock_Timeout), 32'd1);
    chk("tmo_unlocked", 32'(bus.o_Locked), 32'd0);
    chk("tmo_byte_held", 32'(bus.o_TX_Byte), 32'h51);
    chk("tmo_no_ready", 32'(bus.o_Req_Ready), 32'd0);
    xfer(2'd2, 8'h62, 1, 1'b0);
    chk("tmo_one_cycle", 32'(bus.o_Lock_Timeout), 32'd0);
    set_req(2'd2, 1'b0, 8'h00, 1'b0);

    // 5: req3 withdraws during its accept cycle; no DV, pointer still at 3
    phase = "t5_withdraw";
    set_req(2'd3, 1'b1, 8'h73, 1'b1);
    set_req(2'd0, 1'b1, 8'h80, 1'b1);
    wait_ready(100, n);
    chk("wd_latency", 32'(n), 32'(LAT));
    chk("wd_ready", 32'(bus.o_Req_Ready), 32'h8);
    set_req(2'd3, 1'b0, 8'h73, 1'b1);
    step();
    chk("wd_no_dv", 32'(bus.o_TX_DV), 32'd0);
    chk("wd_not_busy", 32'(bus.o_Busy), 32'd0);
    chk("wd_no_ready", 32'(bus.o_Req_Ready), 32'd0);
    set_req(2'd3, 1'b1, 8'h73, 1'b1);
    xfer(2'd3, 8'h73, 1, 1'b0);
    set_req(2'd3, 1'b0, 8'h00, 1'b0);
    xfer(2'd0, 8'h80, LAT, 1'b0);
    set_req(2'd0, 1'b0, 8'h00, 1'b0);

    // 6: reset mid-frame while req1 holds a lock; lock and pointer cleared, full drain
    phase = "t6_reset";
    set_req(2'd1, 1'b1, 8'h91, 1'b0);
    xfer(2'd1, 8'h91, LAT, 1'b1);
    set_req(2'd1, 1'b1, 8'h92, 1'b1);
    set_req(2'd0, 1'b1, 8'hA0, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    step();
    chk_reset();
    rst = 1'b0;
    xfer(2'd0, 8'hA0, LAT, 1'b0);
    set_req(2'd0, 1'b0, 8'h00, 1'b0);
    xfer(2'd1, 8'h92, LAT, 1'b0);
    set_req(2'd1, 1'b0, 8'h00, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
